// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states, source
// numbering and the fixed-priority vector encoder.
package intc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam int         NUM_SOURCES = 9;
  localparam logic [3:0] VEC_TIMER   = 4'h0;
  localparam logic [3:0] VEC_GPIO0   = 4'h1;
  localparam logic [3:0] VEC_NONE    = 4'hF;

  // Lowest set index wins; bit 0 (timer) has the highest priority.
  function automatic logic [3:0] prio_vec(input logic [NUM_SOURCES-1:0] pend);
    logic [3:0] v;
    v = VEC_NONE;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pend[i]) begin
        v = (i == 0) ? VEC_TIMER : VEC_GPIO0 + 4'(i - 1);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/intc_timer.sv
// Free-running periodic timer: counts hwclk cycles and emits a one-cycle
// tick every i_duration cycles while enabled.
module intc_timer (
  input  logic        hwclk,
  input  logic        nrst,
  input  logic        i_enable,
  input  logic [31:0] i_duration,
  output logic        o_tick
);

  logic [31:0] r_count;
  logic        r_tick;
  logic        w_wrap;

  // Durations 0 and 1 both wrap every cycle; ">=" also catches a duration
  // lowered below the running count, so the counter never overruns.
  assign w_wrap = (i_duration <= 32'd1) || (r_count >= i_duration - 32'd1);

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (!i_enable) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (w_wrap) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + 32'd1;
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: GPIO edge capture, timer source, pending register,
// fixed-priority encoder and the IDLE/REQ/SERVICE handshake with the CPU.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   hwclk,
  input  logic                   nrst,
  input  logic [7:0]             gpio_interrupt_pins,
  input  logic [7:0]             gpio_interrupt_mask,
  input  logic                   timer_enable,
  input  logic [31:0]            timer_duration,
  input  logic                   irq_ack,
  input  logic                   irq_done,
  output logic                   irq,
  output logic [3:0]             irq_vector,
  output logic [NUM_SOURCES-1:0] irq_pending,
  output logic                   timer_tick
);

  state_t                 r_state;
  logic                   r_irq;
  logic [3:0]             r_vec;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [7:0]             r_edge;
  logic [7:0]             w_sync;
  logic [7:0]             w_rise;
  logic                   w_tick;
  logic [3:0]             w_winner;
  logic [NUM_SOURCES-1:0] w_set;
  logic [NUM_SOURCES-1:0] w_clear;
  logic [NUM_SOURCES-1:0] w_pending_next;

  intc_timer u_timer (
    .hwclk      (hwclk),
    .nrst       (nrst),
    .i_enable   (timer_enable),
    .i_duration (timer_duration),
    .o_tick     (w_tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pin
      logic [SYNC_STAGES-1:0] r_chain;
      always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) r_chain <= '0;
        else       r_chain <= {r_chain[SYNC_STAGES-2:0], gpio_interrupt_pins[gi]};
      end
      assign w_sync[gi] = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) r_edge <= '0;
    else       r_edge <= w_sync;
  end

  // Masked edges are dropped outright rather than remembered for later.
  assign w_rise   = w_sync & ~r_edge;
  assign w_set    = {w_rise & gpio_interrupt_mask, w_tick};
  assign w_winner = prio_vec(r_pending);
  assign w_clear  = (r_state == REQ && irq_ack)
                    ? (NUM_SOURCES'(1) << w_winner) : '0;
  // A set arriving on the same edge as its clear must survive.
  assign w_pending_next = (r_pending & ~w_clear) | w_set;

  // The vector follows the next pending value so that in REQ it always
  // equals the winner of the pending bits currently visible.
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_irq     <= 1'b0;
      r_vec     <= VEC_NONE;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        IDLE: begin
          if (r_pending != '0) begin
            r_state <= REQ;
            r_irq   <= 1'b1;
            r_vec   <= prio_vec(w_pending_next);
          end
        end
        REQ: begin
          if (irq_ack) begin
            r_state <= SERVICE;
            r_irq   <= 1'b0;
            r_vec   <= w_winner;
          end else begin
            r_vec   <= prio_vec(w_pending_next);
          end
        end
        SERVICE: begin
          if (irq_done) begin
            r_state <= IDLE;
            r_vec   <= VEC_NONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
          r_vec   <= VEC_NONE;
        end
      endcase
    end
  end

  assign irq         = r_irq;
  assign irq_vector  = r_vec;
  assign irq_pending = r_pending;
  assign timer_tick  = w_tick;

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of GPIO synchronizer flops per pin; legal values are 2 or 3.
REQ-002 Port hwclk, input, 1: system clock; all state changes on its rising edge.
REQ-003 Port nrst, input, 1: reset, asynchronous, active-low.
REQ-004 Port gpio_interrupt_pins, input, 8: raw GPIO input levels; pins configured as outputs are already gated to 0 upstream.
REQ-005 Port gpio_interrupt_mask, input, 8: per-pin interrupt enable; 1 = enabled.
REQ-006 Port timer_enable, input, 1: periodic timer run enable.
REQ-007 Port timer_duration, input, 32: timer period in hwclk cycles.
REQ-008 Port irq_ack, input, 1: CPU accepts the interrupt currently requested.
REQ-009 Port irq_done, input, 1: CPU finished its handler (return from interrupt).
REQ-010 Port irq, output, 1: interrupt request to the CPU.
REQ-011 Port irq_vector, output, 4: source index; 0 = timer, 1..8 = GPIO0..GPIO7, 4'hF = none.
REQ-012 Port irq_pending, output, 9: pending register; bit 0 = timer, bits 1..8 = GPIO0..GPIO7.
REQ-013 Port timer_tick, output, 1: one-cycle pulse at each timer period boundary.

Function
REQ-014 Timer counter (32-bit) while timer_enable=0: counter forced to 0; timer_tick forced to 0.
REQ-015 Timer while timer_enable=1: counter increments every cycle.
  - When counter >= timer_duration-1, the counter loads 0 and timer_tick is 1 in the following cycle.
  - Period is exactly timer_duration cycles; first tick occurs timer_duration cycles after the enabling edge.
REQ-016 timer_duration 0 and 1 both mean a tick every cycle.
  - A duration decrease below the current count causes a wrap on the next edge; no 2^32 overrun.
REQ-017 GPIO synchronization: each pin passes through SYNC_STAGES flops, then an edge register.
  - A rising edge of a synchronized pin with its mask bit =1 sets the corresponding irq_pending bit.
  - Edges on masked pins are discarded, not deferred.
REQ-018 GPIO latency (SYNC_STAGES=2): pin first sampled high at edge k.
  - irq_pending bit is high after edge k+2.
  - irq is high after edge k+3 when the FSM is IDLE.
REQ-019 timer_tick=1 sets irq_pending[0] on the same edge on which the tick is seen.
REQ-020 Clearing a mask bit does not clear an already-pending bit.
REQ-021 If a bit is set and cleared in the same cycle, the set wins.
REQ-022 Priority: lowest pending index wins (timer highest, GPIO7 lowest).
REQ-023 FSM IDLE: irq=0, irq_vector=4'hF; if irq_pending != 0, go to REQ.
REQ-024 FSM REQ: irq=1; irq_vector tracks the highest-priority pending bit each cycle.
  - On irq_ack: irq_vector is frozen to the current winner, that pending bit is cleared, and the FSM goes to SERVICE.
  - irq is 0 from the next cycle.
REQ-025 FSM SERVICE: irq=0; irq_vector holds the acknowledged source.
  - New events keep latching into irq_pending.
  - On irq_done: go to IDLE (vector 4'hF).
REQ-026 irq_ack outside REQ and irq_done outside SERVICE are ignored.
  - If both are asserted in REQ, only irq_ack is acted upon.
REQ-027 Pending events remaining after SERVICE re-request: IDLE goes to REQ one cycle after returning to IDLE.

Reset
REQ-028 While nrst=0, the following are cleared to 0: counter, synchronizers, edge registers, irq_pending, irq and timer_tick.
  - The FSM is in IDLE and irq_vector=4'hF.
REQ-029 Reset mid-operation (REQ or SERVICE) abandons the interrupt; no pending state survives.
  - The first tick after reset release obeys REQ-015.

Structure
REQ-030 Package intc_pkg holds the following shared definitions:
  - FSM enum {IDLE, REQ, SERVICE}
  - NUM_SOURCES=9
  - VEC_TIMER=4'h0
  - VEC_GPIO0=4'h1
  - VEC_NONE=4'hF
REQ-031 Sub-module intc_timer contains the counter and the tick generation (REQ-014..016).
  - All other logic (synchronizers, pending register, priority encoder, FSM) resides in interrupt_controller.

Verification
REQ-032 Timer period: timer_enable=1, timer_duration=5, all masks 0.
  - timer_tick pulses every 5 cycles, first pulse 5 cycles after enable.
  - irq_vector=0 once the FSM reaches REQ.
REQ-033 GPIO latency: mask=8'h08, rising edge on pin 3.
  - irq_pending=9'h010 after 2 edges; irq=1 with irq_vector=4 after 3 edges.
  - The same edge on pin 2 with its mask bit 0 produces no pending bit.
REQ-034 Priority: pins 1 and 6 rise together, mask=8'hFF.
  - First ack: vector=2, pending=9'h080.
  - After irq_done: re-request with vector=7.
REQ-035 Event during SERVICE: timer tick arrives while in SERVICE for source 5.
  - irq stays 0 and pending[0]=1.
  - irq_done is followed by irq=1 with vector=0.
REQ-036 Boundaries:
  - timer_duration=0 gives a tick every cycle.
  - Duration changed from 1000 to 3 at count 500 gives a wrap on the next edge.
  - nrst pulsed during REQ gives irq=0, vector=4'hF, pending=0 immediately.
